// File: rtl/gcd_lcm_coproc.sv
// gcd_lcm_coproc: multi-cycle GCD/LCM coprocessor for the single-cycle RISC-V datapath.
// GCD is computed by Euclidean subtraction, one step per cycle. LCM is (a*b)/gcd,
// using a 16-step restoring divider.
// Build option: define COP_LCM_EN to include the product register, the multiplier and
// the divider. Without it, an LCM command answers with the unsupported flag set.
module gcd_lcm_coproc (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [31:0] CopData,
  output logic [31:0] copAns
);

  typedef enum logic [1:0] {IDLE, GCD, DIV, DONE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  a_q, a_nxt;
  logic [7:0]  b_q, b_nxt;
  logic        op_q, op_nxt;
  logic [7:0]  result_q, result_nxt;
  logic        ovf_q, ovf_nxt;
  logic        unsup_q, unsup_nxt;
  logic [7:0]  gcd_val;

  // The high command bits carry no meaning for this unit.
  logic        unused_cmd_bits;
  assign unused_cmd_bits = ^CopData[31:17];

  // Once one working operand reaches zero, the other one is the GCD.
  assign gcd_val = a_q | b_q;

`ifdef COP_LCM_EN
  // p_q first holds the product a*b. In DIV it is the dividend/quotient shift
  // register: each cycle a dividend bit leaves at the top and a quotient bit
  // enters at the bottom. After 16 shifts it holds the quotient. The divisor
  // is gcd_val, because A and B do not change while in DIV.
  logic [15:0] p_q, p_nxt;
  logic [7:0]  rem_q, rem_nxt;
  logic [3:0]  cnt_q, cnt_nxt;
  logic [8:0]  rem_shift;
  logic [8:0]  rem_diff;
  logic        q_bit;
  logic [15:0] quo_shift;

  // One restoring-division step: shift the next dividend bit in, then try the subtraction.
  always_comb begin
    rem_shift = {rem_q, p_q[15]};
    rem_diff  = rem_shift - {1'b0, gcd_val};
    q_bit     = (rem_shift >= {1'b0, gcd_val});
    quo_shift = {p_q[14:0], q_bit};
  end
`endif

  // Next-state and datapath update logic. Every register holds its value by default.
  always_comb begin
    // NOTE: every variable gets a default before the case statement. Without
    // these defaults, a path that does not assign one would infer a latch.
    state_nxt  = state;
    a_nxt      = a_q;
    b_nxt      = b_q;
    op_nxt     = op_q;
    result_nxt = result_q;
    ovf_nxt    = ovf_q;
    unsup_nxt  = unsup_q;
`ifdef COP_LCM_EN
    p_nxt      = p_q;
    rem_nxt    = rem_q;
    cnt_nxt    = cnt_q;
`endif
    case (state)
      IDLE: begin
        if (Start) begin
          a_nxt     = CopData[7:0];
          b_nxt     = CopData[15:8];
          op_nxt    = CopData[16];
`ifdef COP_LCM_EN
          if (CopData[16]) p_nxt = {8'h00, CopData[7:0]} * {8'h00, CopData[15:8]};
`endif
          state_nxt = GCD;
        end
      end
      GCD: begin
        if (!Start) begin
          state_nxt = IDLE;
        end else if (a_q != 8'h00 && b_q != 8'h00) begin
          if (a_q >= b_q) a_nxt = a_q - b_q;
          else            b_nxt = b_q - a_q;
        end else if (!op_q) begin
          result_nxt = gcd_val;
          ovf_nxt    = 1'b0;
          unsup_nxt  = 1'b0;
          state_nxt  = DONE;
        end else begin
`ifdef COP_LCM_EN
          // A zero product means one operand was zero, so the LCM is 0 and the
          // divider is skipped. This also covers gcd == 0.
          if (p_q == 16'h0000) begin
            result_nxt = 8'h00;
            ovf_nxt    = 1'b0;
            unsup_nxt  = 1'b0;
            state_nxt  = DONE;
          end else begin
            rem_nxt   = 8'h00;
            cnt_nxt   = 4'd0;
            state_nxt = DIV;
          end
`else
          result_nxt = 8'h00;
          ovf_nxt    = 1'b0;
          unsup_nxt  = 1'b1;
          state_nxt  = DONE;
`endif
        end
      end
      DIV: begin
`ifdef COP_LCM_EN
        if (!Start) begin
          state_nxt = IDLE;
        end else begin
          rem_nxt = q_bit ? rem_diff[7:0] : rem_shift[7:0];
          p_nxt   = quo_shift;
          cnt_nxt = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            result_nxt = quo_shift[7:0];
            ovf_nxt    = |quo_shift[15:8];
            unsup_nxt  = 1'b0;
            state_nxt  = DONE;
          end
        end
`else
        state_nxt = IDLE;
`endif
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. All registers
    // then update together at the edge, however the statements are ordered.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Working operands, result and flag registers, plus divider state.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      op_q     <= 1'b0;
      result_q <= 8'h00;
      ovf_q    <= 1'b0;
      unsup_q  <= 1'b0;
`ifdef COP_LCM_EN
      p_q      <= 16'h0000;
      rem_q    <= 8'h00;
      cnt_q    <= 4'd0;
`endif
    end else begin
      a_q      <= a_nxt;
      b_q      <= b_nxt;
      op_q     <= op_nxt;
      result_q <= result_nxt;
      ovf_q    <= ovf_nxt;
      unsup_q  <= unsup_nxt;
`ifdef COP_LCM_EN
      p_q      <= p_nxt;
      rem_q    <= rem_nxt;
      cnt_q    <= cnt_nxt;
`endif
    end
  end

  // Response word. Done comes straight from the registered DONE state.
  assign copAns = {21'h0, unsup_q, ovf_q, (state == DONE), result_q};

endmodule

// File: tb/tb_gcd_lcm_coproc.sv
// tb_gcd_lcm_coproc: directed, self-checking bench for gcd_lcm_coproc.
// Expected LCM results depend on whether COP_LCM_EN is defined.
module tb_gcd_lcm_coproc;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [31:0] CopData;
  logic [31:0] copAns;

  int checks = 0;
  int errors = 0;

  gcd_lcm_coproc dut (
    .clk     (clk),
    .reset   (reset),
    .Start   (Start),
    .CopData (CopData),
    .copAns  (copAns)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Launch one command from IDLE. Check the edge count to done and the done word,
  // then check the held result after done drops.
  task automatic run_cmd(input logic [31:0] word, input int exp_edges,
                         input logic [31:0] exp_ans, input string tag);
    int n;
    Start   = 1'b1;
    CopData = word;
    tick();                       // edge L
    CopData = 32'hFFFF_FFFF;      // must be ignored after launch
    n = 0;
    while (copAns[8] !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(exp_edges));
    check({tag, " done word"}, copAns, exp_ans);
    Start = 1'b0;
    tick();
    check({tag, " held"}, copAns, exp_ans & ~32'h100);
  endtask

  initial begin
    int n;
    int pulses;

    reset   = 1'b1;
    Start   = 1'b0;
    CopData = 32'h0;
    tick();
    tick();
    reset = 1'b0;
    check("reset state", copAns, 32'h0);

    run_cmd(32'h0000_080C, 4,   32'h104, "gcd_12_8");
    run_cmd(32'h0000_0000, 1,   32'h100, "gcd_0_0");
    run_cmd(32'hFFFE_0609, 4,   32'h103, "gcd_9_6_upper_ignored");
    run_cmd(32'h0000_2315, 5,   32'h107, "gcd_21_35");
    run_cmd(32'h0000_01FF, 256, 32'h101, "gcd_255_1");
`ifdef COP_LCM_EN
    run_cmd(32'h0001_0604, 20,  32'h10C, "lcm_4_6");
    run_cmd(32'h0001_96C8, 21,  32'h358, "lcm_200_150");
    run_cmd(32'h0001_0700, 1,   32'h100, "lcm_0_7");
    run_cmd(32'h0001_0A0F, 20,  32'h11E, "lcm_15_10");
`else
    run_cmd(32'h0001_0604, 4,   32'h500, "lcm_4_6 unsup");
    run_cmd(32'h0001_96C8, 5,   32'h500, "lcm_200_150 unsup");
    run_cmd(32'h0001_0700, 1,   32'h500, "lcm_0_7 unsup");
    run_cmd(32'h0001_0A0F, 4,   32'h500, "lcm_15_10 unsup");
`endif

    // Back-to-back: Start stays high, and the next command word appears in the done cycle.
    Start   = 1'b1;
    CopData = 32'h0000_080C;
    tick();
    n = 0;
    while (copAns[8] !== 1'b1 && n < 50) begin tick(); n++; end
    check("b2b first latency", 32'(n), 32'd4);
    check("b2b first done", copAns, 32'h104);
    CopData = 32'h0000_0609;
    tick();
    check("b2b gap idle", copAns, 32'h004);
    tick();                       // second launch edge
    n = 0;
    while (copAns[8] !== 1'b1 && n < 50) begin tick(); n++; end
    check("b2b second latency", 32'(n), 32'd4);
    check("b2b second done", copAns, 32'h103);
    Start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (copAns[8] === 1'b1) pulses++;
    end
    check("b2b no third pulse", 32'(pulses), 32'd0);
    check("b2b result held", copAns, 32'h003);

    // Abort: Start drops in the middle of a long GCD.
    Start   = 1'b1;
    CopData = 32'h0000_01FF;
    tick();
    for (int i = 0; i < 5; i++) tick();
    Start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (copAns[8] === 1'b1) pulses++;
    end
    check("abort no done", 32'(pulses), 32'd0);
    check("abort result kept", copAns, 32'h003);

    // Reset in mid-operation: mid-DIV for LCM builds, mid-GCD otherwise.
    Start = 1'b1;
`ifdef COP_LCM_EN
    CopData = 32'h0001_0604;
`else
    CopData = 32'h0000_01FF;
`endif
    tick();
    for (int i = 0; i < 8; i++) tick();
    reset = 1'b1;
    Start = 1'b0;
    tick();
    check("mid-op reset clears", copAns, 32'h0);
    reset = 1'b0;
    tick();
    tick();
    check("after reset idle", copAns, 32'h0);
    run_cmd(32'h0000_080C, 4, 32'h104, "gcd_12_8 after reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
